// File: rtl/bsg_cover_pkg.sv
// bsg_cover_pkg: shared cover-point types, FSM states and code-width helper
package bsg_cover_pkg;
  localparam int cover_flag_w_lp = 2;
  typedef enum logic [0:0] {eArm, eRun} state_e;
  typedef struct packed {
    logic [15:0] idx;
    logic dir;
    logic hit;
  } cover_point_s;
  function automatic int cover_min_width(input int n);
    return $clog2(n) + cover_flag_w_lp;
  endfunction
endpackage

// File: rtl/bsg_priority_encode.sv
// bsg_priority_encode: index of the lowest (lo_to_hi_p) or highest set bit
module bsg_priority_encode #(
  parameter int width_p = 2,
  parameter int lo_to_hi_p = 1
) (
  input  logic [width_p-1:0]         i,
  output logic [$clog2(width_p)-1:0] addr_o,
  output logic                       v_o
);
  localparam int aw = $clog2(width_p);
  always_comb begin
    addr_o = '0;
    v_o = |i;
    for (int k = 0; k < width_p; k++)
      if (i[lo_to_hi_p != 0 ? width_p-1-k : k]) addr_o = aw'(lo_to_hi_p != 0 ? width_p-1-k : k);
  end
endmodule

// File: rtl/bsg_cover_toggle_gen.sv
// bsg_cover_toggle_gen: per-bit toggle detector draining cover codes one per cycle (BSG_COVER_TOGGLE_GEN_FILTER_EN: emit each pair once per reset)
module bsg_cover_toggle_gen
  import bsg_cover_pkg::*;
#(
  parameter int num_sig_p = 4,
  parameter int width_p = 8
) (
  input  logic                 core_clk_i,
  input  logic                 core_reset_n_i,
  input  logic                 en_i,
  input  logic [num_sig_p-1:0] sig_i,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 ready_i,
  output logic                 pending_o,
  output logic [31:0]          count_o
);
  localparam int nb = 2 * num_sig_p;
  localparam int aw = $clog2(nb);
  state_e state_r;
  logic [num_sig_p-1:0] prev_r;
  logic [nb-1:0] pend_r, raw, elig, set, clr;
  logic v_r, load, take, pe_v;
  logic [width_p-1:0] data_r;
  logic [31:0] count_r;
  logic [aw-1:0] addr;
  cover_point_s cp;
  for (genvar i = 0; i < num_sig_p; i++) begin : g_dir
    assign raw[2*i+1] = sig_i[i] & ~prev_r[i];
    assign raw[2*i] = ~sig_i[i] & prev_r[i];
  end
  bsg_priority_encode #(.width_p(nb), .lo_to_hi_p(1)) u_pe (
    .i(pend_r),
    .addr_o(addr),
    .v_o(pe_v)
  );
  assign load = ~v_r | ready_i;
  assign take = load & pe_v;
  assign clr = take ? nb'(1) << addr : '0;
`ifdef BSG_COVER_TOGGLE_GEN_FILTER_EN
  logic [nb-1:0] seen_r;
  assign elig = ~(seen_r | clr);
  always_ff @(posedge core_clk_i)
    if (!core_reset_n_i) seen_r <= '0;
    else seen_r <= seen_r | clr;
`else
  assign elig = '1;
`endif
  assign set = (en_i && state_r == eRun) ? raw & elig : '0;
  assign cp = '{idx: 16'(addr >> 1), dir: addr[0], hit: 1'b1};
  always_ff @(posedge core_clk_i) begin
    prev_r <= sig_i;
    if (!core_reset_n_i) begin
      state_r <= eArm;
      pend_r <= '0;
      v_r <= 1'b0;
      data_r <= '0;
      count_r <= '0;
    end else begin
      state_r <= eRun;
      pend_r <= (pend_r & ~clr) | set;
      if (load) v_r <= pe_v;
      if (take) data_r <= width_p'(cp);
      if (v_r && ready_i && !(&count_r)) count_r <= count_r + 32'd1;
    end
  end
  assign v_o = v_r;
  assign data_o = data_r;
  assign pending_o = |pend_r;
  assign count_o = count_r;
endmodule

// File: tb/tb_bsg_cover_toggle_gen.sv
// tb_bsg_cover_toggle_gen: table-driven and directed checks of the toggle cover generator
module tb_bsg_cover_toggle_gen;
  logic clk = 1'b0, rst_n, en, ready, v, pend;
  logic [3:0] sig;
  logic [7:0] data;
  logic [31:0] cnt;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] sig;
    logic en, rdy, v;
    logic [7:0] data;
    logic pend;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[20];
  bsg_cover_toggle_gen #(.num_sig_p(4), .width_p(8)) dut (
    .core_clk_i(clk),
    .core_reset_n_i(rst_n),
    .en_i(en),
    .sig_i(sig),
    .v_o(v),
    .data_o(data),
    .ready_i(ready),
    .pending_o(pend),
    .count_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int n05, n07, n_first;
    logic [31:0] c0;
    logic [7:0] first;
    tbl[0] = '{4'b1010, 1, 1, 0, 8'h00, 0, 0};
    tbl[1] = '{4'b1010, 1, 1, 0, 8'h00, 0, 0};
    tbl[2] = '{4'b1010, 1, 1, 0, 8'h00, 0, 0};
    tbl[3] = '{4'b1010, 1, 1, 0, 8'h00, 0, 0};
    tbl[4] = '{4'b1110, 1, 1, 0, 8'h00, 1, 0};
    tbl[5] = '{4'b1110, 1, 1, 1, 8'h0B, 0, 0};
    tbl[6] = '{4'b1110, 1, 1, 0, 8'h00, 0, 1};
    tbl[7] = '{4'b0110, 0, 1, 0, 8'h00, 0, 1};
    tbl[8] = '{4'b0110, 1, 1, 0, 8'h00, 0, 1};
    tbl[9] = '{4'b1111, 1, 0, 0, 8'h00, 1, 1};
    for (int i = 10; i < 15; i++) tbl[i] = '{4'b1111, 1, 0, 1, 8'h03, 1, 1};
    tbl[15] = '{4'b1111, 1, 1, 1, 8'h0F, 0, 2};
    tbl[16] = '{4'b1111, 1, 1, 0, 8'h00, 0, 3};
    tbl[17] = '{4'b1101, 0, 1, 0, 8'h00, 0, 3};
    tbl[18] = '{4'b1111, 0, 1, 0, 8'h00, 0, 3};
    tbl[19] = '{4'b1111, 1, 1, 0, 8'h00, 0, 3};
    rst_n = 1'b0; en = 1'b1; ready = 1'b1; sig = 4'b1010;
    step();
    step();
    chk("reset_v", 32'(v), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_pending", 32'(pend), 0);
    chk("reset_count", cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sig = tbl[i].sig; en = tbl[i].en; ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_v", i), 32'(v), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].data));
      chk($sformatf("vec%0d_pending", i), 32'(pend), 32'(tbl[i].pend));
      chk($sformatf("vec%0d_count", i), cnt, tbl[i].cnt);
    end
    c0 = cnt; n05 = 0; n07 = 0; n_first = 0; first = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) sig[1] = ~sig[1];
      step();
      if (v) begin
        if (n_first == 0) first = data;
        n_first++;
        if (data == 8'h05) n05++;
        else if (data == 8'h07) n07++;
        else chk("toggle_code", 32'(data), 32'h05);
      end
    end
    chk("toggle_first", 32'(first), 32'h05);
`ifdef BSG_COVER_TOGGLE_GEN_FILTER_EN
    chk("toggle_n05", n05, 1);
    chk("toggle_n07", n07, 1);
    chk("toggle_count", cnt - c0, 2);
`else
    chk("toggle_n05", n05, 4);
    chk("toggle_n07", n07, 4);
    chk("toggle_count", cnt - c0, 8);
`endif
    ready = 1'b0; sig = 4'b0000;
    step();
    step();
    chk("pre_rst_v", 32'(v), 1);
    chk("pre_rst_data", 32'(data), 32'h01);
    chk("pre_rst_pending", 32'(pend), 1);
    rst_n = 1'b0; sig = 4'b1010;
    step();
    chk("mid_rst_v", 32'(v), 0);
    chk("mid_rst_pending", 32'(pend), 0);
    chk("mid_rst_count", cnt, 0);
    rst_n = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rearm%0d_v", i), 32'(v), 0);
      chk($sformatf("rearm%0d_pending", i), 32'(pend), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
